// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory port arbiter: state encoding and memory geometry.
package mem_port_arbiter_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam int ADDR_W_DEF = 16;
  localparam int MEM_DEPTH  = 1 << ADDR_W_DEF;
endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (IF) and data (D); grant is same-cycle,
// read data/valid one cycle later; a losing requester simply holds its request.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic        ifGnt,
  output logic [31:0] ifRdata,
  output logic        ifValid,
  input  logic        dReq,
  input  logic        dWe,
  input  logic        dLock,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic        dGnt,
  output logic [31:0] dRdata,
  output logic        dValid,
  output logic [31:0] memAddress,
  output logic [31:0] memWritedata,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memReaddata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          post_lock_q, post_lock_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  logic          if_gnt, d_gnt;
  logic [31:0]   sel_addr;
  logic          unused_addr_bits;

  // Grants are gated by reset so every output drops the instant reset asserts.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst) begin
      if (state_q == ST_LOCK) begin
        d_gnt = dReq;
      end else if (ifReq && (post_lock_q || starve_cnt_q == SW'(STARVE_MAX))) begin
        if_gnt = 1'b1;
      end else if (dReq) begin
        d_gnt = 1'b1;
      end else if (ifReq) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    post_lock_d  = 1'b0;
    starve_cnt_d = '0;
    if (state_q == ST_IDLE) begin
      lock_cnt_d = '0;
      if (d_gnt && dLock) begin
        state_d    = ST_LOCK;
        lock_cnt_d = LW'(1);
      end
    end else begin
      lock_cnt_d = lock_cnt_q + 1'b1;
      if (!dLock) begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end else if (lock_cnt_d == LW'(LOCK_MAX)) begin
        // Lock budget spent: one idle cycle in which a waiting fetch is guaranteed to win.
        state_d     = ST_IDLE;
        post_lock_d = 1'b1;
      end
    end
    if (ifReq && !if_gnt) begin
      starve_cnt_d = (starve_cnt_q == SW'(STARVE_MAX)) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    if_valid_d = if_gnt;
    d_valid_d  = d_gnt;
    if_rdata_d = if_gnt ? memReaddata : if_rdata_q;
    d_rdata_d  = (d_gnt && !dWe) ? memReaddata : d_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      lock_cnt_q   <= '0;
      post_lock_q  <= 1'b0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      post_lock_q  <= post_lock_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign sel_addr         = d_gnt ? dAddr : ifAddr;
  assign unused_addr_bits = ^sel_addr[31:ADDR_W];

  assign ifGnt        = if_gnt;
  assign dGnt         = d_gnt;
  assign ifValid      = if_valid_q;
  assign dValid       = d_valid_q;
  assign ifRdata      = if_rdata_q;
  assign dRdata       = d_rdata_q;
  assign memAddress   = (if_gnt || d_gnt) ? {{(32-ADDR_W){1'b0}}, sel_addr[ADDR_W-1:0]} : 32'd0;
  assign memRead      = if_gnt || (d_gnt && !dWe);
  assign memWrite     = d_gnt && dWe;
  assign memWritedata = (d_gnt && dWe) ? dWdata : 32'd0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a rule-level reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int LOCK_MAX   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, dReq, dWe, dLock;
  logic [31:0] ifAddr, dAddr, dWdata;
  logic        ifGnt, ifValid, dGnt, dValid, memRead, memWrite;
  logic [31:0] ifRdata, dRdata, memAddress, memWritedata, memReaddata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W_DEF), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifRdata(ifRdata), .ifValid(ifValid),
    .dReq(dReq), .dWe(dWe), .dLock(dLock), .dAddr(dAddr), .dWdata(dWdata),
    .dGnt(dGnt), .dRdata(dRdata), .dValid(dValid),
    .memAddress(memAddress), .memWritedata(memWritedata), .memRead(memRead),
    .memWrite(memWrite), .memReaddata(memReaddata)
  );

  // Environment memory (driven by the DUT) and the model's own view of memory.
  logic [31:0] mem     [0:MEM_DEPTH-1];
  logic [31:0] ref_mem [0:MEM_DEPTH-1];
  assign memReaddata = mem[memAddress[15:0]];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: fetch losses in a row, cycles spent in the current lock.
  int          m_starve, m_lock;
  bit          m_post;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  bit          obs_if_gnt, obs_d_gnt, obs_mem_write;
  logic [31:0] obs_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve     = 0;
    m_lock       = 0;
    m_post       = 0;
    exp_if_rdata = 32'd0;
    exp_d_rdata  = 32'd0;
  endtask

  // One cycle: drive at posedge+1, check grant side at negedge, check responses at posedge+1.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic dl, input logic [31:0] da, input logic [31:0] dd);
    bit          g_if, g_d, w;
    logic [31:0] a, exp_addr, rd, wd;
    logic [15:0] wa;
    ifReq = ir; ifAddr = ia; dReq = dr; dWe = dw; dLock = dl; dAddr = da; dWdata = dd;
    @(negedge clk);
    g_if = 0;
    g_d  = 0;
    if (m_lock > 0) g_d = dr;
    else if (ir && (m_post || m_starve >= STARVE_MAX)) g_if = 1;
    else if (dr) g_d = 1;
    else if (ir) g_if = 1;
    a        = g_d ? da : ia;
    exp_addr = (g_if || g_d) ? (a % MEM_DEPTH) : 32'd0;
    check("ifGnt", 32'(ifGnt), 32'(g_if));
    check("dGnt", 32'(dGnt), 32'(g_d));
    check("memAddress", memAddress, exp_addr);
    check("memRead", 32'(memRead), 32'(g_if || (g_d && !dw)));
    check("memWrite", 32'(memWrite), 32'(g_d && dw));
    check("memWritedata", memWritedata, (g_d && dw) ? dd : 32'd0);
    obs_if_gnt    = ifGnt;
    obs_d_gnt     = dGnt;
    obs_mem_write = memWrite;
    obs_addr      = memAddress;
    w  = memWrite;
    wa = memAddress[15:0];
    wd = memWritedata;
    rd = ref_mem[exp_addr % MEM_DEPTH];
    @(posedge clk);
    if (w) mem[wa] = wd;
    #1;
    if (g_d && dw) ref_mem[exp_addr % MEM_DEPTH] = dd;
    if (g_if) exp_if_rdata = rd;
    if (g_d && !dw) exp_d_rdata = rd;
    if (ir && !g_if) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else m_starve = 0;
    if (m_lock == 0) begin
      m_post = 0;
      if (g_d && dl) m_lock = 1;
    end else if (!dl) begin
      m_lock = 0;
    end else if (m_lock + 1 == LOCK_MAX) begin
      m_lock = 0;
      m_post = 1;
    end else begin
      m_lock++;
    end
    check("ifValid", 32'(ifValid), 32'(g_if));
    check("dValid", 32'(dValid), 32'(g_d));
    check("ifRdata", ifRdata, exp_if_rdata);
    check("dRdata", dRdata, exp_d_rdata);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [9:0]  pat3;
    logic [11:0] pat4_if, pat4_d;

    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem[i]     = (i * 32'h9E37_79B1) ^ 32'h5A00_0000;
      ref_mem[i] = (i * 32'h9E37_79B1) ^ 32'h5A00_0000;
    end
    mem[10]     = 32'hA5A5_A5A5;
    ref_mem[10] = 32'hA5A5_A5A5;
    model_reset();

    rst = 1'b0;
    ifReq = 1'b0; dReq = 1'b0; dWe = 1'b0; dLock = 1'b0;
    ifAddr = 32'd0; dAddr = 32'd0; dWdata = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_ifValid", 32'(ifValid), 32'd0);
    check("reset_dValid", 32'(dValid), 32'd0);
    check("reset_ifRdata", ifRdata, 32'd0);
    check("reset_dRdata", dRdata, 32'd0);
    check("reset_memAddress", memAddress, 32'd0);
    rst = 1'b1;

    // Fetch read of word 10.
    step(1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t1_ifGnt", 32'(obs_if_gnt), 32'd1);
    check("t1_ifRdata", ifRdata, 32'hA5A5_A5A5);

    // Data write then read-back of word 2000.
    step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd2000, 32'd7);
    check("t2_memWrite", 32'(obs_mem_write), 32'd1);
    idle();
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd2000, 32'd0);
    check("t2_readback", dRdata, 32'd7);

    // Both requesting continuously: fetch wins every fifth cycle.
    idle();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'd100 + i, 1'b1, 1'b0, 1'b0, 32'd200 + i, 32'd0);
      pat3[i] = obs_if_gnt;
    end
    check("t3_if_pattern", 32'(pat3), 32'(10'b10_0001_0000));

    // Held lock: eight data grants, one fetch, then data again.
    idle();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'd300, 1'b1, 1'b0, 1'b1, 32'd400 + i, 32'd0);
      pat4_if[i] = obs_if_gnt;
      pat4_d[i]  = obs_d_gnt;
    end
    check("t4_if_pattern", 32'(pat4_if), 32'(12'b0001_0000_0000));
    check("t4_d_pattern", 32'(pat4_d), 32'(12'b1110_1111_1111));
    idle();
    idle();

    // Upper address bits are dropped.
    step(1'b1, 32'h0001_0003, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t6_wrap_addr", obs_addr, 32'd3);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ia, da, dd;
      ia = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 31));
      da = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 31));
      dd = $urandom();
      step(1'(($urandom() & 3) != 0), ia, 1'(($urandom() & 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), da, dd);
    end

    // Reset in the middle of a granted data write.
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    ifReq = 1'b0; dReq = 1'b1; dWe = 1'b1; dLock = 1'b0; dAddr = 32'd777; dWdata = 32'h0000_1234;
    #2;
    check("t5_pre_dValid", 32'(dValid), 32'd1);
    check("t5_pre_memWrite", 32'(memWrite), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_dGnt", 32'(dGnt), 32'd0);
    check("t5_memWrite", 32'(memWrite), 32'd0);
    check("t5_dValid", 32'(dValid), 32'd0);
    check("t5_memAddress", memAddress, 32'd0);
    @(posedge clk);
    #1;
    check("t5_mem_unchanged", mem[777], ref_mem[777]);
    check("t5_dRdata", dRdata, 32'd0);
    model_reset();
    rst = 1'b1;
    step(1'b1, 32'd10, 1'b1, 1'b0, 1'b0, 32'd777, 32'd0);
    check("t5_post_dGnt", 32'(obs_d_gnt), 32'd1);
    step(1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
